osnt_tstamp_gen: RTL and testbench
==================================

OSNT_TSTAMP_GEN -- requirements
Module: osnt_tstamp_gen

Interface
REQ-001 SHALL have parameter TIMESTAMP_WIDTH, default 64, total timestamp width; upper 32 bits are seconds, lower bits are binary fraction.
REQ-002 SHALL have parameter INC_WIDTH, default 32, width of the per-cycle increment.
REQ-003 SHALL have parameter NUM_CAPTURE, default 4, number of event-capture channels (1..16).
REQ-004 SHALL have parameter C_DEFAULT_ENABLE_CTR, default 1, counter run state out of reset.
REQ-005 SHALL have port axi_aclk  in  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port axi_reset  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port ctr_enable  in  1  counter runs while high; ANDed with the C_DEFAULT_ENABLE_CTR reset state latch.
REQ-008 SHALL have port inc  in  INC_WIDTH  per-cycle increment, zero-extended.
REQ-009 SHALL have port load_valid / load_value  in  1 / TIMESTAMP_WIDTH  one-cycle absolute load.
REQ-010 SHALL have port adj_valid / adj_delta  in  1 / TIMESTAMP_WIDTH  one-cycle signed two's-complement offset.
REQ-011 SHALL have port pps  in  1  asynchronous pulse-per-second input.
REQ-012 SHALL have port pps_stamp / pps_valid  out  TIMESTAMP_WIDTH / 1  timestamp at last PPS edge; one-cycle strobe.
REQ-013 SHALL have port cap_event  in  NUM_CAPTURE  synchronous per-channel event pulses.
REQ-014 SHALL have port cap_ack  in  NUM_CAPTURE  per-channel consume strobe.
REQ-015 SHALL have port cap_stamp  out  NUM_CAPTURE*TIMESTAMP_WIDTH  packed captured values, channel 0 in LSBs.
REQ-016 SHALL have port cap_valid / cap_ovf  out  NUM_CAPTURE / NUM_CAPTURE  holding-register full; sticky overflow.
REQ-017 SHALL have port tstamp  out  TIMESTAMP_WIDTH  registered running timestamp.

Function
REQ-018 Each cycle, the counter SHALL update as follows, highest priority first:
  - load_valid: tstamp <= load_value.
  - adj_valid and run: tstamp <= tstamp + inc + adj_delta.
  - adj_valid and not run: tstamp <= tstamp + adj_delta.
  - run only: tstamp <= tstamp + inc.
  - otherwise: hold.
REQ-019 All counter arithmetic SHALL be modulo 2^TIMESTAMP_WIDTH; wrap from all-ones to low values SHALL be silent.
REQ-020 An adj_valid coincident with load_valid SHALL be discarded.
REQ-021 pps SHALL pass through a 2-flop synchroniser plus an edge register; a rising edge is a 0->1 transition of the synchronised signal.
REQ-022 On a PPS rising edge in cycle N:
  - pps_stamp SHALL take the tstamp value of cycle N, before the update.
  - pps_valid SHALL be high for exactly cycle N+1.
  - pps in-to-edge latency SHALL be 3 cycles.
REQ-023 Each capture channel SHALL be a 2-state FSM:
  - EMPTY -> FULL on cap_event: stamp <= current tstamp (pre-update value), cap_valid=1.
  - FULL -> EMPTY on cap_ack without cap_event.
REQ-024 A cap_event in FULL without cap_ack SHALL set cap_ovf and leave the stored stamp unchanged (first event wins).
REQ-025 cap_event and cap_ack in the same cycle while FULL SHALL overwrite the stamp, keep cap_valid=1, and not set overflow.
REQ-026 cap_ack in EMPTY SHALL have no effect.
REQ-027 cap_ovf SHALL be cleared only by cap_ack with cap_event low.
REQ-028 Channels SHALL be fully independent; simultaneous events on all channels SHALL capture identical stamps.

Reset
REQ-029 While axi_reset is high, the following SHALL hold, overriding all other inputs:
  - tstamp, pps_stamp, all cap_stamp = 0.
  - pps_valid, cap_valid, cap_ovf = 0.
  - synchroniser flops = 0.
  - run-state latch = C_DEFAULT_ENABLE_CTR.
REQ-030 Reset asserted mid-capture or mid-PPS SHALL discard the pending strobe; no pps_valid SHALL appear in the cycle after reset deasserts.
REQ-031 With C_DEFAULT_ENABLE_CTR=0, the counter SHALL stay at 0 regardless of ctr_enable; load and adjust SHALL still operate.

Structure
REQ-032 Package osnt_tstamp_pkg SHALL hold:
  - the seconds-field width constant (32).
  - the default increment constant for a 160 MHz clock (2^32/160e6, rounded).
  - the capture FSM state encoding.
REQ-033 A sub-module osnt_tstamp_capture SHALL implement one capture channel and be instantiated NUM_CAPTURE times by a generate loop.
REQ-034 The adder SHALL be a single registered stage; no multi-cycle paths.

Verification
REQ-035 Increment: reset, inc=0x10, ctr_enable=1 for 5 cycles -> tstamp = 0x50.
REQ-036 Wrap and priority:
  - load 0xFFFF_FFFF_FFFF_FFF8 then run with inc=0x10 -> next value 0x8.
  - load and adjust together -> load value only.
REQ-037 Adjust: tstamp=0x1000, inc=1, adj_delta=-0x100 -> next tstamp=0x0F01.
REQ-038 PPS: pps rises, counter running inc=1 -> pps_valid one cycle exactly 4 cycles after pps first sampled high; pps_stamp = tstamp of the edge cycle.
REQ-039 Capture channel 2:
  - event -> cap_valid[2]=1.
  - second event -> cap_ovf[2]=1, stamp unchanged.
  - event+ack together -> new stamp, cap_ovf still 1.
  - ack alone -> valid and ovf both 0.
REQ-040 Reset mid-run: assert axi_reset with all four channels FULL and a PPS edge in the synchroniser -> all outputs 0 the cycle after, no spurious pps_valid.

Source files
------------

// File: rtl/osnt_tstamp_pkg.sv
// Shared constants and types for the timestamp generator.
package osnt_tstamp_pkg;

  // Seconds occupy the upper 32 bits of a timestamp; the rest is binary fraction.
  localparam int SEC_W = 32;

  // Fraction increment per cycle at 160 MHz: round(2^32 / 160e6) = 27.
  localparam logic [31:0] DEFAULT_INC_160M = 32'd27;

  // Capture holding-register state.
  typedef enum logic {
    CAP_EMPTY = 1'b0,
    CAP_FULL  = 1'b1
  } cap_state_e;

endpackage

// File: rtl/osnt_tstamp_if.sv
// One event-capture channel: event/ack and the live timestamp in, the held stamp out.
interface osnt_tstamp_if #(
  parameter int TW = 64
);
  logic          evt;
  logic          ack;
  logic [TW-1:0] cur;
  logic [TW-1:0] stamp;
  logic          valid;
  logic          ovf;

  modport master (output evt, ack, cur, input stamp, valid, ovf);
  modport slave  (input evt, ack, cur, output stamp, valid, ovf);
endinterface

// File: rtl/osnt_tstamp_capture.sv
// Single capture channel: holds the first stamp taken while empty, flags overflow
// on events that arrive before the held stamp is consumed.
module osnt_tstamp_capture
  import osnt_tstamp_pkg::*;
#(
  parameter int TW = 64
) (
  input  logic axi_aclk,
  input  logic axi_reset,
  osnt_tstamp_if.slave cif
);

  cap_state_e    state_q, state_d;
  logic [TW-1:0] stamp_q, stamp_d;
  logic          ovf_q, ovf_d;

  // State, stamp and overflow registers.
  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      state_q <= CAP_EMPTY;
      stamp_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stamp_q <= stamp_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next state: an event together with an ack while full is a back-to-back
  // consume-and-refill, so it overwrites without counting as overflow.
  always_comb begin
    state_d = state_q;
    stamp_d = stamp_q;
    ovf_d   = ovf_q;
    case (state_q)
      CAP_EMPTY: begin
        if (cif.evt) begin
          state_d = CAP_FULL;
          stamp_d = cif.cur;
        end
      end
      CAP_FULL: begin
        if (cif.evt && cif.ack) begin
          stamp_d = cif.cur;
        end else if (cif.evt) begin
          ovf_d = 1'b1;
        end else if (cif.ack) begin
          state_d = CAP_EMPTY;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = CAP_EMPTY;
    endcase
  end

  // Outputs are straight register views.
  always_comb begin
    cif.valid = (state_q == CAP_FULL);
    cif.stamp = stamp_q;
    cif.ovf   = ovf_q;
  end

endmodule

// File: rtl/osnt_tstamp_gen.sv
// Free-running timestamp counter with load/adjust, PPS stamping and
// per-channel event capture.
module osnt_tstamp_gen
  import osnt_tstamp_pkg::*;
#(
  parameter int TIMESTAMP_WIDTH      = 64,
  parameter int INC_WIDTH            = 32,
  parameter int NUM_CAPTURE          = 4,
  parameter int C_DEFAULT_ENABLE_CTR = 1
) (
  input  logic                                   axi_aclk,
  input  logic                                   axi_reset,
  input  logic                                   ctr_enable,
  input  logic [INC_WIDTH-1:0]                   inc,
  input  logic                                   load_valid,
  input  logic [TIMESTAMP_WIDTH-1:0]             load_value,
  input  logic                                   adj_valid,
  input  logic [TIMESTAMP_WIDTH-1:0]             adj_delta,
  input  logic                                   pps,
  output logic [TIMESTAMP_WIDTH-1:0]             pps_stamp,
  output logic                                   pps_valid,
  input  logic [NUM_CAPTURE-1:0]                 cap_event,
  input  logic [NUM_CAPTURE-1:0]                 cap_ack,
  output logic [NUM_CAPTURE*TIMESTAMP_WIDTH-1:0] cap_stamp,
  output logic [NUM_CAPTURE-1:0]                 cap_valid,
  output logic [NUM_CAPTURE-1:0]                 cap_ovf,
  output logic [TIMESTAMP_WIDTH-1:0]             tstamp
);

  localparam int TW = TIMESTAMP_WIDTH;
  localparam logic RUN_RST = (C_DEFAULT_ENABLE_CTR != 0);

  logic [TW-1:0] tstamp_q, tstamp_d;
  logic [TW-1:0] inc_ext;
  logic          run_en_q;
  logic          run;

  logic          pps_s1_q, pps_s2_q, pps_prev_q, pps_edge_q;
  logic [TW-1:0] pps_stamp_q;
  logic          pps_valid_q;

  assign inc_ext = TW'(inc);
  assign run     = ctr_enable & run_en_q;

  // Run-state latch: fixed at its reset value, gates ctr_enable.
  always_ff @(posedge axi_aclk) begin
    if (axi_reset) run_en_q <= RUN_RST;
    else           run_en_q <= run_en_q;
  end

  // Counter next value: load wins and drops any coincident adjust.
  always_comb begin
    tstamp_d = tstamp_q;
    if (load_valid) begin
      tstamp_d = load_value;
    end else begin
      if (run)       tstamp_d = tstamp_d + inc_ext;
      if (adj_valid) tstamp_d = tstamp_d + adj_delta;
    end
  end

  // Counter register, wraps silently.
  always_ff @(posedge axi_aclk) begin
    if (axi_reset) tstamp_q <= '0;
    else           tstamp_q <= tstamp_d;
  end

  // PPS synchroniser, edge register and stamp; edge_q marks the edge cycle.
  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      pps_s1_q    <= 1'b0;
      pps_s2_q    <= 1'b0;
      pps_prev_q  <= 1'b0;
      pps_edge_q  <= 1'b0;
      pps_stamp_q <= '0;
      pps_valid_q <= 1'b0;
    end else begin
      pps_s1_q    <= pps;
      pps_s2_q    <= pps_s1_q;
      pps_prev_q  <= pps_s2_q;
      pps_edge_q  <= pps_s2_q & ~pps_prev_q;
      pps_valid_q <= pps_edge_q;
      if (pps_edge_q) pps_stamp_q <= tstamp_q;
    end
  end

  assign tstamp    = tstamp_q;
  assign pps_stamp = pps_stamp_q;
  assign pps_valid = pps_valid_q;

  // Capture channels all see the same pre-update timestamp.
  for (genvar g = 0; g < NUM_CAPTURE; g++) begin : g_cap
    osnt_tstamp_if #(.TW(TW)) cif ();

    assign cif.evt = cap_event[g];
    assign cif.ack = cap_ack[g];
    assign cif.cur = tstamp_q;

    osnt_tstamp_capture #(.TW(TW)) u_cap (
      .axi_aclk  (axi_aclk),
      .axi_reset (axi_reset),
      .cif       (cif)
    );

    assign cap_stamp[g*TW +: TW] = cif.stamp;
    assign cap_valid[g]          = cif.valid;
    assign cap_ovf[g]            = cif.ovf;
  end

endmodule

// File: tb/tb_osnt_tstamp_gen.sv
// Directed bench: counter vector table, then PPS, capture and reset sequences.
module tb_osnt_tstamp_gen;

  logic         clk = 1'b0;
  logic         axi_reset;
  logic         ctr_enable;
  logic [31:0]  inc;
  logic         load_valid;
  logic [63:0]  load_value;
  logic         adj_valid;
  logic [63:0]  adj_delta;
  logic         pps;
  logic [63:0]  pps_stamp, pps_stamp0;
  logic         pps_valid, pps_valid0;
  logic [3:0]   cap_event, cap_ack;
  logic [255:0] cap_stamp, cap_stamp0;
  logic [3:0]   cap_valid, cap_valid0, cap_ovf, cap_ovf0;
  logic [63:0]  tstamp, tstamp0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  osnt_tstamp_gen #(.C_DEFAULT_ENABLE_CTR(1)) dut (
    .axi_aclk(clk), .axi_reset(axi_reset), .ctr_enable(ctr_enable), .inc(inc),
    .load_valid(load_valid), .load_value(load_value),
    .adj_valid(adj_valid), .adj_delta(adj_delta), .pps(pps),
    .pps_stamp(pps_stamp), .pps_valid(pps_valid),
    .cap_event(cap_event), .cap_ack(cap_ack), .cap_stamp(cap_stamp),
    .cap_valid(cap_valid), .cap_ovf(cap_ovf), .tstamp(tstamp)
  );

  // Same stimulus, counter disabled out of reset.
  osnt_tstamp_gen #(.C_DEFAULT_ENABLE_CTR(0)) dut0 (
    .axi_aclk(clk), .axi_reset(axi_reset), .ctr_enable(ctr_enable), .inc(inc),
    .load_valid(load_valid), .load_value(load_value),
    .adj_valid(adj_valid), .adj_delta(adj_delta), .pps(pps),
    .pps_stamp(pps_stamp0), .pps_valid(pps_valid0),
    .cap_event(cap_event), .cap_ack(cap_ack), .cap_stamp(cap_stamp0),
    .cap_valid(cap_valid0), .cap_ovf(cap_ovf0), .tstamp(tstamp0)
  );

  // Channel-2 view bundled through the channel interface.
  osnt_tstamp_if #(.TW(64)) ch2 ();
  assign ch2.evt   = cap_event[2];
  assign ch2.ack   = cap_ack[2];
  assign ch2.cur   = tstamp;
  assign ch2.stamp = cap_stamp[191:128];
  assign ch2.valid = cap_valid[2];
  assign ch2.ovf   = cap_ovf[2];

  typedef struct {
    logic        ld;
    logic [63:0] ldv;
    logic        adj;
    logic [63:0] adjv;
    logic        en;
    logic [31:0] inc;
    logic [63:0] exp;
    logic [63:0] exp0;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 32'h10, 64'h10, 64'h0};
    vecs[1]  = '{1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 32'h10, 64'h20, 64'h0};
    vecs[2]  = '{1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 32'h10, 64'h30, 64'h0};
    vecs[3]  = '{1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 32'h10, 64'h40, 64'h0};
    vecs[4]  = '{1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 32'h10, 64'h50, 64'h0};
    vecs[5]  = '{1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 64'h0, 1'b1, 32'h10,
                 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8};
    vecs[6]  = '{1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 32'h10, 64'h8, 64'hFFFF_FFFF_FFFF_FFF8};
    vecs[7]  = '{1'b1, 64'h1234, 1'b1, 64'h55, 1'b1, 32'h10, 64'h1234, 64'h1234};
    vecs[8]  = '{1'b1, 64'h1000, 1'b0, 64'h0, 1'b0, 32'h0, 64'h1000, 64'h1000};
    vecs[9]  = '{1'b0, 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FF00, 1'b1, 32'h1, 64'h0F01, 64'h0F00};
    vecs[10] = '{1'b0, 64'h0, 1'b1, 64'h5, 1'b0, 32'h1, 64'h0F06, 64'h0F05};
    vecs[11] = '{1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 32'h1, 64'h0F06, 64'h0F05};
    vecs[12] = '{1'b0, 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 32'h1, 64'h0F05, 64'h0F04};
    vecs[13] = '{1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 32'hFFFF_FFFF, 64'h1_0000_0F04, 64'h0F04};

    axi_reset = 1'b1; ctr_enable = 1'b1; inc = 32'h10;
    load_valid = 1'b0; load_value = '0; adj_valid = 1'b0; adj_delta = '0;
    pps = 1'b0; cap_event = '0; cap_ack = '0;

    // Reset holds everything at zero even with the counter enabled.
    repeat (2) begin
      cyc();
      chk("rst_tstamp", tstamp, 64'h0);
      chk("rst_pps_valid", {63'h0, pps_valid}, 64'h0);
      chk("rst_cap_valid", {60'h0, cap_valid}, 64'h0);
    end

    // Counter vector table.
    axi_reset = 1'b0;
    for (int i = 0; i < 14; i++) begin
      load_valid = vecs[i].ld;  load_value = vecs[i].ldv;
      adj_valid  = vecs[i].adj; adj_delta  = vecs[i].adjv;
      ctr_enable = vecs[i].en;  inc        = vecs[i].inc;
      cyc();
      chk($sformatf("vec%0d_tstamp", i), tstamp, vecs[i].exp);
      chk($sformatf("vec%0d_tstamp_noen", i), tstamp0, vecs[i].exp0);
    end
    adj_valid = 1'b0; load_valid = 1'b0;

    // PPS: presented with a load of 0x100, edge cycle sees 0x102.
    ctr_enable = 1'b1; inc = 32'h1; load_valid = 1'b1; load_value = 64'h100; pps = 1'b1;
    cyc(); load_valid = 1'b0;
    chk("pps_c1_valid", {63'h0, pps_valid}, 64'h0);
    cyc(); chk("pps_c2_valid", {63'h0, pps_valid}, 64'h0);
    cyc(); chk("pps_c3_valid", {63'h0, pps_valid}, 64'h0);
    cyc(); chk("pps_c4_valid", {63'h0, pps_valid}, 64'h1);
    chk("pps_stamp", pps_stamp, 64'h102);
    cyc(); chk("pps_c5_valid", {63'h0, pps_valid}, 64'h0);
    cyc(); chk("pps_hold_valid", {63'h0, pps_valid}, 64'h0);
    pps = 1'b0;

    // Capture channel 2 with the counter stopped.
    ctr_enable = 1'b0; load_valid = 1'b1; load_value = 64'h500;
    cyc(); load_valid = 1'b0; cap_event = 4'b0100;
    cyc();
    chk("cap_first_valid", {60'h0, cap_valid}, 64'h4);
    chk("cap_first_stamp", ch2.stamp, 64'h500);
    chk("cap_first_ovf", {63'h0, ch2.ovf}, 64'h0);
    cap_event = 4'b0000; load_valid = 1'b1; load_value = 64'h600;
    cyc(); load_valid = 1'b0; cap_event = 4'b0100;
    cyc();
    chk("cap_ovf_set", {63'h0, ch2.ovf}, 64'h1);
    chk("cap_ovf_stamp", ch2.stamp, 64'h500);
    chk("cap_ovf_valid", {63'h0, ch2.valid}, 64'h1);
    cap_event = 4'b0000; load_valid = 1'b1; load_value = 64'h700;
    cyc(); load_valid = 1'b0; cap_event = 4'b0100; cap_ack = 4'b0100;
    cyc();
    chk("cap_evack_stamp", ch2.stamp, 64'h700);
    chk("cap_evack_valid", {63'h0, ch2.valid}, 64'h1);
    chk("cap_evack_ovf", {63'h0, ch2.ovf}, 64'h1);
    cap_event = 4'b0000;
    cyc();
    chk("cap_ack_valid", {63'h0, ch2.valid}, 64'h0);
    chk("cap_ack_ovf", {63'h0, ch2.ovf}, 64'h0);
    cyc();
    chk("cap_ack_empty_valid", {63'h0, ch2.valid}, 64'h0);
    chk("cap_ack_empty_stamp", ch2.stamp, 64'h700);
    cap_ack = 4'b0000; cap_event = 4'b0100; load_valid = 1'b1; load_value = 64'h900;
    cyc();
    chk("cap_preupdate_stamp", ch2.stamp, 64'h700);
    chk("cap_preupdate_tstamp", tstamp, 64'h900);
    load_valid = 1'b0; cap_event = 4'b0000; cap_ack = 4'b0100;
    cyc(); cap_ack = 4'b0000;

    // All channels at once while running.
    cap_event = 4'b1111; ctr_enable = 1'b1; inc = 32'h3;
    cyc(); cap_event = 4'b0000;
    chk("cap_all_valid", {60'h0, cap_valid}, 64'hF);
    for (int c = 0; c < 4; c++)
      chk($sformatf("cap_all_stamp%0d", c), cap_stamp[c*64 +: 64], 64'h900);
    chk("cap_all_tstamp", tstamp, 64'h903);

    // Reset with all channels full and a PPS edge inside the synchroniser.
    pps = 1'b1;
    cyc(); pps = 1'b0; axi_reset = 1'b1;
    cyc();
    chk("mrst_tstamp", tstamp, 64'h0);
    chk("mrst_pps_stamp", pps_stamp, 64'h0);
    chk("mrst_pps_valid", {63'h0, pps_valid}, 64'h0);
    chk("mrst_cap_valid", {60'h0, cap_valid}, 64'h0);
    chk("mrst_cap_ovf", {60'h0, cap_ovf}, 64'h0);
    for (int c = 0; c < 4; c++)
      chk($sformatf("mrst_cap_stamp%0d", c), cap_stamp[c*64 +: 64], 64'h0);
    axi_reset = 1'b0;
    cyc();
    chk("post_rst_tstamp", tstamp, 64'h3);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("post_rst_pps_valid%0d", k), {63'h0, pps_valid}, 64'h0);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
